// File: rtl/cache_fill_fsm_if.sv
// Bundle between the cache miss-fill controller and its pipeline/memory/data-array neighbours.
// master = the fill controller, slave = the surrounding cache datapath.
interface cache_fill_fsm_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_array_word;
  logic [15:0] write_data;
  logic        write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_enable, memory_address, write_data_array,
           data_array_word, write_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_enable, memory_address, write_data_array,
           data_array_word, write_data, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: issues one word read per cycle for the missing block,
// counts returning words into the data array and writes the tag with the last word.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8
) (
  input logic              clk,
  input logic              rst,
  cache_fill_fsm_if.master bus
);

  localparam int          OFF_BITS  = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [15:0] BASE_MASK = 16'hFFFF << OFF_BITS;
  localparam logic [3:0]  WPB       = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0]  LAST_WORD = 4'(WORDS_PER_BLOCK - 1);

  typedef enum logic {IDLE, FILL} state_t;

  // Both word counters advance through the same 4-bit incrementer.
  function automatic logic [3:0] incrementer_4_bit(input logic [3:0] a);
    return a + 4'd1;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  recv_cnt_q, recv_cnt_d;
  logic [15:0] base_q, base_d;

  logic        fsm_busy;
  logic        mem_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_array_word;
  logic [15:0] write_data;
  logic        write_tag_array;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 4'd0;
      base_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    base_d           = base_q;
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    memory_address   = 16'd0;
    write_data_array = 1'b0;
    data_array_word  = 3'd0;
    write_data       = 16'd0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          base_d      = bus.miss_address & BASE_MASK;
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 4'd0;
          state_d     = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        // Issue gating saturates the request counter at the block size.
        if (issue_cnt_q < WPB) begin
          mem_enable     = 1'b1;
          memory_address = base_q + {11'd0, issue_cnt_q, 1'b0};
          issue_cnt_d    = incrementer_4_bit(issue_cnt_q);
        end
        if (bus.memory_data_valid) begin
          write_data_array = 1'b1;
          data_array_word  = recv_cnt_q[2:0];
          write_data       = bus.memory_data;
          recv_cnt_d       = incrementer_4_bit(recv_cnt_q);
          if (recv_cnt_q == LAST_WORD) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fsm_busy         = fsm_busy;
  assign bus.mem_enable       = mem_enable;
  assign bus.memory_address   = memory_address;
  assign bus.write_data_array = write_data_array;
  assign bus.data_array_word  = data_array_word;
  assign bus.write_data       = write_data;
  assign bus.write_tag_array  = write_tag_array;

endmodule
